// File: rtl/shot_sequencer.sv
// shot_sequencer: one artillery turn for the naval-battle board.
// It debounces the fire button and latches the target coordinates.
// It then looks up the ship matrix and the shot history, and issues one fire strobe.
// It also keeps the shots-remaining and hit counters and decides win or loss.
// Optional macro LED_TIMEOUT_EN: LEDEN drops LED_HOLD cycles after the last
// shot instead of staying lit until the game is cleared.
module shot_sequencer #(
  parameter int ROW_W        = 3,
  parameter int COL_W        = 3,
  parameter int CNT_W        = 5,
  parameter int MAX_SHOTS    = 20,
  parameter int SHIP_CELLS   = 9,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LED_HOLD     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CH0,
  input  logic             BTN,
  input  logic [ROW_W-1:0] ROWSEL,
  input  logic [COL_W-1:0] COLSEL,
  input  logic             SHIPBIT,
  input  logic             HISTBIT,
  output logic [ROW_W-1:0] ROWADDR,
  output logic [COL_W-1:0] COLADDR,
  output logic             FIRE,
  output logic             HITWR,
  output logic             REPEAT,
  output logic             LEDEN,
  output logic [CNT_W-1:0] SHOTS,
  output logic [CNT_W-1:0] HITS,
  output logic             GAMEOVER,
  output logic             WIN
);

  typedef enum logic [2:0] {IDLE, ARM, LATCH, LOOKUP, SHOOT, WAITREL, DONE} state_t;

  // The debounce counter only has to reach DEBOUNCE_CYC-1.
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  // The IDLE detection cycle counts as the first stable high cycle.
  // ARM therefore accepts the press when the counter reaches DEBOUNCE_CYC-2.
  localparam logic [DB_W-1:0] ARM_LAST = DB_W'((DEBOUNCE_CYC > 1) ? DEBOUNCE_CYC - 2 : 0);
  localparam logic [DB_W-1:0] REL_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SHOTS_INIT = CNT_W'(MAX_SHOTS);
  localparam logic [CNT_W-1:0] HITS_WIN   = CNT_W'(SHIP_CELLS);

  state_t            state_reg, state_next;
  logic [DB_W-1:0]   db_reg, db_next;
  logic [CNT_W-1:0]  shots_reg, shots_next;
  logic [CNT_W-1:0]  hits_reg, hits_next;
  logic              win_reg, win_next;
  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic              leden_reg;
  logic              latch_en;
  logic              led_set;
  logic              fire_c, hitwr_c, repeat_c;

  // State, debounce, counters and target address; CH0 low clears the game.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      db_reg    <= '0;
      shots_reg <= SHOTS_INIT;
      hits_reg  <= '0;
      win_reg   <= 1'b0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else if (!CH0) begin
      state_reg <= IDLE;
      db_reg    <= '0;
      shots_reg <= SHOTS_INIT;
      hits_reg  <= '0;
      win_reg   <= 1'b0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      db_reg    <= db_next;
      shots_reg <= shots_next;
      hits_reg  <= hits_next;
      win_reg   <= win_next;
      if (latch_en) begin
        row_reg <= ROWSEL;
        col_reg <= COLSEL;
      end
    end
  end

  // Next-state logic and the one-cycle strobes issued in SHOOT.
  always_comb begin
    state_next = state_reg;
    db_next    = db_reg;
    shots_next = shots_reg;
    hits_next  = hits_reg;
    win_next   = win_reg;
    latch_en   = 1'b0;
    led_set    = 1'b0;
    fire_c     = 1'b0;
    hitwr_c    = 1'b0;
    repeat_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (BTN) begin
          db_next    = '0;
          state_next = (DEBOUNCE_CYC <= 1) ? LATCH : ARM;
        end
      end
      ARM: begin
        if (!BTN) begin
          state_next = IDLE;
        end else if (db_reg == ARM_LAST) begin
          state_next = LATCH;
        end else begin
          db_next = db_reg + 1'b1;
        end
      end
      LATCH: begin
        latch_en   = 1'b1;
        state_next = LOOKUP;
      end
      LOOKUP: begin
        state_next = SHOOT;
      end
      SHOOT: begin
        fire_c     = 1'b1;
        led_set    = 1'b1;
        shots_next = shots_reg - 1'b1;
        if (SHIPBIT && !HISTBIT) begin
          hitwr_c   = 1'b1;
          hits_next = hits_reg + 1'b1;
        end else if (SHIPBIT && HISTBIT) begin
          repeat_c = 1'b1;
        end
        // A win takes precedence when the last shot also sinks the last cell.
        if (hits_next == HITS_WIN) begin
          state_next = DONE;
          win_next   = 1'b1;
        end else if (shots_next == '0) begin
          state_next = DONE;
          win_next   = 1'b0;
        end else begin
          state_next = WAITREL;
          db_next    = '0;
        end
      end
      WAITREL: begin
        if (BTN) begin
          db_next = '0;
        end else if (db_reg == REL_LAST) begin
          db_next    = '0;
          state_next = IDLE;
        end else begin
          db_next = db_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A shot that is being cleared by CH0 must not reach the gunner or history.
    if (!CH0) begin
      fire_c   = 1'b0;
      hitwr_c  = 1'b0;
      repeat_c = 1'b0;
    end
  end

`ifdef LED_TIMEOUT_EN
  localparam int LT_W = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;
  logic [LT_W-1:0] led_tmr_reg;

  // LED enable: lit for LED_HOLD cycles after each shot, then held lit once the game is over.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      leden_reg   <= 1'b0;
      led_tmr_reg <= '0;
    end else if (!CH0) begin
      leden_reg   <= 1'b0;
      led_tmr_reg <= '0;
    end else if (led_set) begin
      leden_reg   <= 1'b1;
      led_tmr_reg <= LT_W'(LED_HOLD - 1);
    end else if (leden_reg && state_reg != DONE) begin
      if (led_tmr_reg == '0) begin
        leden_reg <= 1'b0;
      end else begin
        led_tmr_reg <= led_tmr_reg - 1'b1;
      end
    end
  end
`else
  // LED enable: lit from the first shot until the game is cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      leden_reg <= 1'b0;
    end else if (!CH0) begin
      leden_reg <= 1'b0;
    end else if (led_set) begin
      leden_reg <= 1'b1;
    end
  end
`endif

  assign ROWADDR  = row_reg;
  assign COLADDR  = col_reg;
  assign FIRE     = fire_c;
  assign HITWR    = hitwr_c;
  assign REPEAT   = repeat_c;
  assign LEDEN    = leden_reg;
  assign SHOTS    = shots_reg;
  assign HITS     = hits_reg;
  assign GAMEOVER = (state_reg == DONE);
  assign WIN      = win_reg;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer.
// Instance a uses the default parameters.
// Instance b (2 shots, 1 ship cell) covers game-over.
// Both instances share the same stimulus.
module tb_shot_sequencer;
  logic       CLK = 1'b0;
  logic       RST, CH0, BTN, SHIPBIT, HISTBIT;
  logic [2:0] ROWSEL, COLSEL;

  logic [2:0] a_rowaddr, a_coladdr, b_rowaddr, b_coladdr;
  logic       a_fire, a_hitwr, a_repeat, a_leden, a_gameover, a_win;
  logic       b_fire, b_hitwr, b_repeat, b_leden, b_gameover, b_win;
  logic [4:0] a_shots, a_hits, b_shots, b_hits;

  int total = 0;
  int bad   = 0;

  // Results of the most recent shot() call.
  int   nf_a, nf_b, ff_a, fall_a;
  logic hw_a, rp_a;

  shot_sequencer dut_a (
    .CLK(CLK), .RST(RST), .CH0(CH0), .BTN(BTN), .ROWSEL(ROWSEL), .COLSEL(COLSEL),
    .SHIPBIT(SHIPBIT), .HISTBIT(HISTBIT), .ROWADDR(a_rowaddr), .COLADDR(a_coladdr),
    .FIRE(a_fire), .HITWR(a_hitwr), .REPEAT(a_repeat), .LEDEN(a_leden),
    .SHOTS(a_shots), .HITS(a_hits), .GAMEOVER(a_gameover), .WIN(a_win)
  );

  shot_sequencer #(.MAX_SHOTS(2), .SHIP_CELLS(1)) dut_b (
    .CLK(CLK), .RST(RST), .CH0(CH0), .BTN(BTN), .ROWSEL(ROWSEL), .COLSEL(COLSEL),
    .SHIPBIT(SHIPBIT), .HISTBIT(HISTBIT), .ROWADDR(b_rowaddr), .COLADDR(b_coladdr),
    .FIRE(b_fire), .HITWR(b_hitwr), .REPEAT(b_repeat), .LEDEN(b_leden),
    .SHOTS(b_shots), .HITS(b_hits), .GAMEOVER(b_gameover), .WIN(b_win)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end else begin
      $display("ok   %s = %0d", tag, $signed(got));
    end
  endtask

  // Hold BTN for hold_n cycles, then release it for rel_n cycles, sampling at each falling edge.
  // Index i is the i-th falling edge after the press starts.
  // A press from IDLE is accepted at edge 4, so FIRE is expected at index 6.
  // The switches are scrambled right after the latch edge to prove they are ignored.
  task automatic shot(input int hold_n, input int rel_n, input logic [2:0] r, input logic [2:0] c);
    nf_a = 0; nf_b = 0; ff_a = -1; fall_a = -1; hw_a = 1'b0; rp_a = 1'b0;
    ROWSEL = r; COLSEL = c;
    for (int i = 1; i <= hold_n + rel_n; i++) begin
      BTN = (i <= hold_n);
      @(negedge CLK);
      if (a_fire) begin
        nf_a++;
        if (ff_a < 0) ff_a = i;
        hw_a = a_hitwr;
        rp_a = a_repeat;
      end
      if (b_fire) nf_b++;
      if (ff_a >= 0 && i > ff_a && !a_leden && fall_a < 0) fall_a = i - ff_a;
      if (i == 5) begin
        ROWSEL = ~r;
        COLSEL = ~c;
      end
    end
    BTN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CH0 = 1'b1; BTN = 1'b0; SHIPBIT = 1'b0; HISTBIT = 1'b0;
    ROWSEL = '0; COLSEL = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Reset state
    chk("rst_shots", a_shots, 20);
    chk("rst_hits", a_hits, 0);
    chk("rst_leden", a_leden, 0);
    chk("rst_gameover", a_gameover, 0);
    chk("rst_win", a_win, 0);
    chk("rst_rowaddr", a_rowaddr, 0);

    // A press that lasts only 3 cycles is rejected
    shot(3, 6, 3'd1, 3'd1);
    chk("short_nfire", nf_a, 0);
    chk("short_shots", a_shots, 20);

    // First hit at (2,5); holding BTN for 50 cycles must not fire a second shot
    SHIPBIT = 1'b1; HISTBIT = 1'b0;
    shot(50, 12, 3'd2, 3'd5);
    chk("hit_nfire", nf_a, 1);
    chk("hit_latency", ff_a, 6);
    chk("hit_hitwr", hw_a, 1);
    chk("hit_repeat", rp_a, 0);
    chk("hit_hits", a_hits, 1);
    chk("hit_shots", a_shots, 19);
    chk("hit_rowaddr", a_rowaddr, 2);
    chk("hit_coladdr", a_coladdr, 5);
`ifdef LED_TIMEOUT_EN
    chk("led_fall", fall_a, 9);
`else
    chk("led_nofall", fall_a, -1);
    repeat (100) @(negedge CLK);
    chk("led_hold100", a_leden, 1);
`endif

    // A repeat shot at an already-hit cell consumes a shot but scores no hit
    HISTBIT = 1'b1;
    shot(4, 12, 3'd2, 3'd5);
    chk("rep_nfire", nf_a, 1);
    chk("rep_repeat", rp_a, 1);
    chk("rep_hitwr", hw_a, 0);
    chk("rep_hits", a_hits, 1);
    chk("rep_shots", a_shots, 18);

    // An asynchronous reset asserted mid-ARM takes effect immediately
    BTN = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_shots", a_shots, 20);
    chk("arst_hits", a_hits, 0);
    chk("arst_leden", a_leden, 0);
    chk("arst_fire", a_fire, 0);
    @(negedge CLK);
    RST = 1'b0; BTN = 1'b0;
    @(negedge CLK);

    // Instance b: a miss and then a hit wins on the last shot
    SHIPBIT = 1'b0; HISTBIT = 1'b0;
    shot(4, 12, 3'd0, 3'd0);
    chk("b_miss_shots", b_shots, 1);
    chk("b_miss_gameover", b_gameover, 0);
    SHIPBIT = 1'b1;
    shot(4, 12, 3'd3, 3'd3);
    chk("b_win_nfire", nf_b, 1);
    chk("b_win_gameover", b_gameover, 1);
    chk("b_win_win", b_win, 1);
    chk("b_win_shots", b_shots, 0);
    chk("b_win_hits", b_hits, 1);

    // In DONE, presses are ignored and the counters stay frozen
    shot(6, 6, 3'd3, 3'd3);
    chk("b_done_nfire", nf_b, 0);
    chk("b_done_shots", b_shots, 0);
    chk("b_done_gameover", b_gameover, 1);

    // CH0 held low for one edge clears the game
    CH0 = 1'b0;
    @(negedge CLK);
    CH0 = 1'b1;
    chk("ch0_shots", b_shots, 2);
    chk("ch0_hits", b_hits, 0);
    chk("ch0_gameover", b_gameover, 0);
    chk("ch0_win", b_win, 0);
    chk("ch0_leden", b_leden, 0);

    // Instance b: two misses lose the game
    SHIPBIT = 1'b0;
    shot(4, 12, 3'd1, 3'd2);
    shot(4, 12, 3'd1, 3'd3);
    chk("b_loss_gameover", b_gameover, 1);
    chk("b_loss_win", b_win, 0);
    chk("b_loss_shots", b_shots, 0);
    chk("b_loss_hits", b_hits, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Controls one artillery turn for the naval-battle board: debounces the fire button, latches the target coordinates, addresses the ship matrix and the shot history, then issues one fire pulse to the gunner.
- Keeps the remaining-shot and hit counters, drives the LED-display enable and decides game over (win or loss).
- Sits between the board switches/button and the gunner, the ship matrix and the history memory.

Parameters:
- ROW_W, 3, width of the row coordinate
- COL_W, 3, width of the column coordinate
- CNT_W, 5, width of the shot and hit counters
- MAX_SHOTS, 20, shots available per game (must be < 2^CNT_W)
- SHIP_CELLS, 9, total ship cells on the board; a win occurs when HITS reaches it
- DEBOUNCE_CYC, 4, consecutive stable cycles needed to accept a press or a release (≥1)
- LED_HOLD, 8, cycles that LEDEN stays high after a shot (only used with the optional feature)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- CH0  in  1  main ON/OFF switch; 0 = synchronous game clear
- BTN  in  1  raw fire button, active-high
- ROWSEL  in  ROW_W  target row from switches
- COLSEL  in  COL_W  target column from switches
- SHIPBIT  in  1  ship-matrix pixel at ROWADDR/COLADDR; combinational, valid the cycle after the address changes
- HISTBIT  in  1  history pixel at the same address: 1 = cell already hit
- ROWADDR  out  ROW_W  registered matrix/history row address
- COLADDR  out  COL_W  registered column address
- FIRE  out  1  one-cycle strobe to the gunner button input
- HITWR  out  1  one-cycle history write strobe (new hit)
- REPEAT  out  1  one-cycle strobe: shot at an already-hit cell
- LEDEN  out  1  LED RGB display enable
- SHOTS  out  CNT_W  shots remaining
- HITS  out  CNT_W  distinct cells hit
- GAMEOVER  out  1  game finished, level
- WIN  out  1  valid while GAMEOVER=1; 1 = all ships sunk

Behaviour:
- RST (asynchronous) or CH0=0 (sampled on the clock edge, any state) loads: state IDLE, SHOTS=MAX_SHOTS, HITS=0, address=0, debounce counter=0, all strobes/LEDEN/GAMEOVER/WIN=0.
- CH0=0 has priority over every transition; a shot in progress is abandoned with no counter change.
- FSM states: IDLE, ARM, LATCH, LOOKUP, SHOOT, WAITREL, DONE.
- IDLE: BTN=1 -> ARM, debounce counter cleared.
- ARM: counter increments while BTN=1; BTN=0 -> IDLE. After DEBOUNCE_CYC consecutive high cycles (counting the IDLE detection cycle) -> LATCH.
- LATCH: ROWADDR/COLADDR <= ROWSEL/COLSEL -> LOOKUP. Switch changes after this edge are ignored for the shot.
- LOOKUP: wait one cycle for matrix/history data -> SHOOT.
- SHOOT (exactly one cycle):
  - FIRE=1; SHOTS decrements by 1.
  - If SHIPBIT=1 and HISTBIT=0: HITWR=1 and HITS increments.
  - If SHIPBIT=1 and HISTBIT=1: REPEAT=1, no HITWR, HITS unchanged; the shot is still consumed.
  - LEDEN <= 1.
  - Next state uses the updated counts: HITS==SHIP_CELLS -> DONE with WIN=1 (win wins a tie on the last shot); else SHOTS==0 -> DONE with WIN=0; else WAITREL.
- FIRE-to-HITWR latency: same cycle. Press accepted to FIRE: 3 cycles (LATCH, LOOKUP, SHOOT).
- WAITREL: needs DEBOUNCE_CYC consecutive BTN=0 cycles -> IDLE; a bounce restarts the count. Holding BTN never fires a second shot.
- DONE: GAMEOVER=1, WIN held, BTN ignored, counters frozen; left only by RST or CH0=0.
- Counters never wrap: SHOTS saturates at 0 and HITS at SHIP_CELLS by construction.

Optional Feature:
- Macro LED_TIMEOUT_EN.
- Defined: LEDEN clears after LED_HOLD cycles counted from the SHOOT cycle; a new SHOOT reloads the timer. In DONE, LEDEN stays 1.
- Undefined: LEDEN stays 1 from the first SHOOT until RST or CH0=0.

Test Plan:
- RST pulse mid-ARM -> immediately SHOTS=20, HITS=0, LEDEN=0, FIRE=0; state IDLE.
- BTN high 3 cycles then low, DEBOUNCE_CYC=4 -> no FIRE, SHOTS stays 20.
- Row=2, col=5, SHIPBIT=1, HISTBIT=0, BTN held 4 cycles -> FIRE and HITWR in the same cycle, 3 cycles after acceptance; HITS=1, SHOTS=19, ROWADDR=2, COLADDR=5. Holding BTN 50 cycles gives no second FIRE.
- Second shot at the same cell with HISTBIT=1 -> FIRE=1, REPEAT=1, HITWR=0; HITS=1, SHOTS=18.
- MAX_SHOTS=2, SHIP_CELLS=1: miss then hit -> GAMEOVER=1, WIN=1, SHOTS=0. Further presses give no FIRE. CH0 low for one edge -> SHOTS=2, GAMEOVER=0.
- With LED_TIMEOUT_EN and LED_HOLD=8: LEDEN falls exactly 8 cycles after the SHOOT cycle. Without the macro, LEDEN is still 1 after 100 cycles.
